// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter sharing one memory read port among NUM_PE processing elements.
// Each request completes with either memory data or a timeout error.
module pe_mem_arbiter #(
   parameter int NUM_PE   = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_PE-1:0]        req_read,
   input  logic [NUM_PE*ADDR_W-1:0] req_addr,
   output logic [NUM_PE-1:0]        req_ack,
   output logic [DATA_W-1:0]        req_data,
   output logic                     req_err,
   output logic                     mem_req,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_rvalid,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic [NUM_PE-1:0]        grant,
   output logic                     busy
);

   // state  | meaning
   // S_IDLE | no owner; pick next requester round-robin from last+1
   // S_WAIT | mem_req held for the owner until mem_rvalid or timeout
   // S_DONE | one-cycle ack gap; requests not sampled so the PE can drop its request

   localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int CW    = PTR_W + 1;
   localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_PE - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   last_q, last_d;
   logic [PTR_W-1:0]   own_q, own_d;
   logic [NUM_PE-1:0]  grant_q, grant_d;
   logic [NUM_PE-1:0]  req_ack_q, req_ack_d;
   logic [DATA_W-1:0]  req_data_q, req_data_d;
   logic               req_err_q, req_err_d;
   logic               mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic               busy_q, busy_d;

   logic               pick_vld;
   logic [PTR_W-1:0]   pick_idx;
   logic [CW-1:0]      cand;

   // Rotating search starting one past the last served PE.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = 0; k < NUM_PE; k++) begin
         cand = {1'b0, last_q} + CW'(k + 1);
         if (cand >= CW'(NUM_PE)) begin
            cand = cand - CW'(NUM_PE);
         end
         if (!pick_vld && req_read[cand[PTR_W-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      own_d      = own_q;
      grant_d    = grant_q;
      req_ack_d  = '0;
      req_data_d = '0;
      req_err_d  = 1'b0;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      case (state_q)
         S_IDLE: begin
            grant_d    = '0;
            mem_req_d  = 1'b0;
            mem_addr_d = '0;
            if (pick_vld) begin
               own_d             = pick_idx;
               grant_d[pick_idx] = 1'b1;
               mem_addr_d        = req_addr[pick_idx*ADDR_W +: ADDR_W];
               mem_req_d         = 1'b1;
               cnt_d             = '0;
               state_d           = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               mem_req_d  = 1'b0;
               req_ack_d  = grant_q;
               req_data_d = mem_rdata;
               last_d     = own_q;
               state_d    = S_DONE;
            end else if (MAX_WAIT != 0 && cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               req_ack_d = grant_q;
               req_err_d = 1'b1;
               last_d    = own_q;
               state_d   = S_DONE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            grant_d    = '0;
            mem_addr_d = '0;
            state_d    = S_IDLE;
         end
         default: begin
            grant_d   = '0;
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         last_q     <= PTR_INIT;
         own_q      <= '0;
         grant_q    <= '0;
         req_ack_q  <= '0;
         req_data_q <= '0;
         req_err_q  <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         own_q      <= own_d;
         grant_q    <= grant_d;
         req_ack_q  <= req_ack_d;
         req_data_q <= req_data_d;
         req_err_q  <= req_err_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         busy_q     <= busy_d;
      end
   end

   assign req_ack  = req_ack_q;
   assign req_data = req_data_q;
   assign req_err  = req_err_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign grant    = grant_q;
   assign busy     = busy_q;

endmodule
